// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and default parameter values.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } ldr_state_e;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DEPTH_LOG2  = 8;
    localparam int unsigned DEF_HOLD_CYCLES = 4;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter: expire_o pulses while enabled and the count sits
// at zero, so a load value of N-1 yields an expire on the Nth enabled cycle.
module hold_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;

    // Count register: load wins, otherwise decrement toward zero while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory, holds the processor in reset
// for a fixed number of cycles after the last write, then releases it.
module imem_boot_loader
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned TW = cnt_width(HOLD_CYCLES);
    localparam logic [DEPTH_LOG2:0] LAST_IDX = {1'b0, {DEPTH_LOG2{1'b1}}};

    ldr_state_e          state_q, state_d;
    logic [DEPTH_LOG2:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;

    logic                accept;
    logic                at_end;
    logic                finish;
    logic                hold_expire;
    logic [ADDR_W-1:0]   word_addr;

    assign in_ready  = (state_q == ST_LOAD);
    assign accept    = in_valid && in_ready;
    // The final slot always terminates the load, marked or not.
    assign at_end    = (count_q == LAST_IDX);
    assign finish    = accept && (in_last || at_end);
    assign word_addr = ADDR_W'(count_q) << 2;

    hold_timer #(.W(TW)) u_hold_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (finish),
        .load_val_i (TW'(HOLD_CYCLES - 1)),
        .en_i       (state_q == ST_HOLD),
        .expire_o   (hold_expire)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        we_d      = accept;
        addr_d    = accept ? word_addr : addr_q;
        wdata_d   = accept ? in_data : wdata_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (at_end && !in_last) ovf_d = 1'b1;
                    if (finish) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_expire) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        // Decoded from the next state so these flip on the same edge as the FSM.
        cpu_rst_d = (state_d != ST_RUN);
        done_d    = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_LOAD;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign cpu_reset  = cpu_rst_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the width of the instruction-memory byte address (matches the PC).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, the log2 of the instruction-memory capacity in words.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 4, the number of cycles cpu_reset stays high after the final write.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock (rising edge).
REQ-005 The block SHALL have port reset, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the program word on in_data is valid.
REQ-007 The block SHALL have port in_data, input, 32 bits, the instruction word.
REQ-008 The block SHALL have port in_last, input, 1 bit, marking the current word as the final word of the program.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the loader accepts a word this cycle.
REQ-010 The block SHALL have port reload, input, 1 bit, a request to restart loading.
REQ-011 The block SHALL have port imem_we, output, 1 bit, the instruction-memory write enable.
REQ-012 The block SHALL have port imem_addr, output, ADDR_W bits, the byte address (word index << 2).
REQ-013 The block SHALL have port imem_wdata, output, 32 bits, the write data.
REQ-014 The block SHALL have port word_count, output, DEPTH_LOG2+1 bits, the number of words accepted in the current load.
REQ-015 The block SHALL have port cpu_reset, output, 1 bit, an active-high reset driven to the Processor.
REQ-016 The block SHALL have port done, output, 1 bit, high while the Processor runs.
REQ-017 The block SHALL have port overflow, output, 1 bit, sticky, set when the memory filled without in_last.

Function
REQ-018 The block SHALL implement an FSM with states LOAD, HOLD and RUN.
REQ-019 in_ready SHALL equal 1 only in LOAD; a word SHALL be accepted on any edge where in_valid and in_ready are both 1.
REQ-020 An accepted word SHALL produce imem_we=1 exactly one cycle later, with imem_wdata equal to the accepted word and imem_addr equal to the pre-increment word_count shifted left by 2; imem_we SHALL be 0 otherwise.
REQ-021 word_count SHALL increment by 1 per accepted word, registered in the same edge as the accept.
REQ-022 Accepting a word with in_last=1 SHALL cause the transition LOAD->HOLD.
REQ-023 Accepting word index 2^DEPTH_LOG2-1 with in_last=0 SHALL set overflow=1 and treat that word as last, causing LOAD->HOLD.
REQ-024 HOLD SHALL last exactly HOLD_CYCLES cycles, then transition HOLD->RUN; the last imem_we pulse falls within HOLD.
REQ-025 cpu_reset SHALL be 1 in LOAD and HOLD and 0 in RUN; done SHALL equal 1 exactly in RUN.
REQ-026 reload=1 in RUN SHALL cause RUN->LOAD on the next edge, clear word_count and overflow, and reassert cpu_reset in the same edge.
REQ-027 reload SHALL be ignored in LOAD and HOLD.
REQ-028 in_valid with in_ready=0 SHALL have no effect, and no word SHALL be dropped.
REQ-029 All outputs SHALL be registered, except in_ready, which is decoded from state.

Reset
REQ-030 Asserting reset=0 at any time, including mid-load, SHALL immediately force: state LOAD, word_count 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, overflow 0, hold counter 0.
REQ-031 After reset is released, the block SHALL be ready to accept word 0 on the first clock edge.

Structure
REQ-032 The state encoding and the default parameter values SHALL reside in the shared package pipeline_pkg.
REQ-033 The hold counter SHALL be the single sub-module hold_timer (load, count down, expire pulse); everything else SHALL be implemented inline.

Verification
REQ-034 A bench SHALL cover: 3 words 0x20080005, 0x20090003, 0x01095020 (last on the third) -> imem_we pulses at addresses 0x0, 0x4, 0x8; word_count=3; cpu_reset falls 4 cycles after entering HOLD; done=1.
REQ-035 A bench SHALL cover: in_valid toggled every other cycle -> writes remain gap-tolerant and in order, with addresses contiguous.
REQ-036 A bench SHALL cover: DEPTH_LOG2=2, 4 words, none with in_last -> overflow=1 after the 4th accept, HOLD entered, and a 5th word not accepted (in_ready=0).
REQ-037 A bench SHALL cover: reset=0 after 2 of 5 words -> all outputs at reset values asynchronously; after release, word 0 is rewritten at address 0x0.
REQ-038 A bench SHALL cover: reload pulse in RUN -> cpu_reset=1 and word_count=0 next cycle, and a new 2-word load targets 0x0 and 0x4.
REQ-039 A bench SHALL cover: reload pulse in HOLD -> ignored, and RUN is reached on schedule.
